ntr_cmd_capture: RTL

Parametrised NTR cartridge-bus command front end. While `cs1` is low it samples one byte of `data` per `clk` cycle and assembles a `CMD_BYTES`-byte command. It then presents the command on a valid/ready handshake and counts the bytes of the following data phase. It sits between the bus pins and the command decoder, and adds abort detection, overrun protection and data-phase accounting.

---
 rtl/ntr_cmd_capture.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ntr_cmd_capture.sv
// NTR cartridge-bus command front end: frame capture, command handshake, data-phase count.
// Optional NTR_CMD_MSB_FIRST_EN places byte 0 in the top byte of `command` (big-endian).
module ntr_cmd_capture #(
    parameter int unsigned CMD_BYTES = 8,
    parameter int unsigned DCNT_W    = 14
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               cs1,
    input  logic [7:0]                         data,
    output logic [8*CMD_BYTES-1:0]             command,
    output logic                               cmd_valid,
    input  logic                               cmd_ready,
    output logic [$clog2(CMD_BYTES+1)-1:0]     byte_count,
    output logic [DCNT_W-1:0]                  data_count,
    output logic                               short_abort,
    output logic                               cmd_overrun
);

    localparam int unsigned CW  = 8 * CMD_BYTES;
    localparam int unsigned BCW = $clog2(CMD_BYTES + 1);

    typedef enum logic [1:0] {SYNC, IDLE, CMD, DATA} state_t;

    state_t            state, state_d;
    logic [CW-1:0]     shreg, shreg_d;
    logic [CW-1:0]     cmd_asm;
    logic [CW-1:0]     command_d;
    logic              cmd_valid_d;
    logic [BCW-1:0]    byte_count_d;
    logic [BCW-1:0]    slot_idx;
    logic [DCNT_W-1:0] data_count_d;
    logic              short_abort_d;
    logic              cmd_overrun_d;
    logic              complete;

    // Next-state, capture assembly and handshake
    always_comb begin
        state_d       = state;
        shreg_d       = shreg;
        command_d     = command;
        cmd_valid_d   = cmd_valid;
        byte_count_d  = byte_count;
        data_count_d  = data_count;
        short_abort_d = 1'b0;
        cmd_overrun_d = 1'b0;
        complete      = 1'b0;
        slot_idx      = byte_count;
        cmd_asm       = shreg;

        // A new frame starts from an empty assembly with the byte in slot 0
        if (state == IDLE) begin
            slot_idx = '0;
            cmd_asm  = '0;
        end
        for (int k = 0; k < CMD_BYTES; k++) begin
            if (slot_idx == BCW'(k)) begin
`ifdef NTR_CMD_MSB_FIRST_EN
                cmd_asm[8*(CMD_BYTES-1-k) +: 8] = data;
`else
                cmd_asm[8*k +: 8] = data;
`endif
            end
        end

        case (state)
            SYNC: begin
                if (cs1) state_d = IDLE;
            end
            IDLE: begin
                if (!cs1) begin
                    shreg_d      = cmd_asm;
                    byte_count_d = BCW'(1);
                    data_count_d = '0;
                    if (CMD_BYTES == 1) begin
                        complete = 1'b1;
                        state_d  = DATA;
                    end else begin
                        state_d  = CMD;
                    end
                end
            end
            CMD: begin
                if (cs1) begin
                    state_d       = IDLE;
                    short_abort_d = 1'b1;
                    shreg_d       = '0;
                    byte_count_d  = '0;
                end else begin
                    shreg_d      = cmd_asm;
                    byte_count_d = byte_count + BCW'(1);
                    if (byte_count == BCW'(CMD_BYTES - 1)) begin
                        complete = 1'b1;
                        state_d  = DATA;
                    end
                end
            end
            DATA: begin
                if (cs1) begin
                    state_d      = IDLE;
                    byte_count_d = '0;
                end else if (data_count != '1) begin
                    data_count_d = data_count + DCNT_W'(1);
                end
            end
            default: state_d = SYNC;
        endcase

        // A completing command wins over consumption; it is dropped only if the old one is stuck
        if (complete) begin
            shreg_d = '0;
            if (cmd_valid && !cmd_ready) begin
                cmd_overrun_d = 1'b1;
            end else begin
                command_d   = cmd_asm;
                cmd_valid_d = 1'b1;
            end
        end else if (cmd_valid && cmd_ready) begin
            cmd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= SYNC;
            shreg       <= '0;
            command     <= '0;
            cmd_valid   <= 1'b0;
            byte_count  <= '0;
            data_count  <= '0;
            short_abort <= 1'b0;
            cmd_overrun <= 1'b0;
        end else begin
            state       <= state_d;
            shreg       <= shreg_d;
            command     <= command_d;
            cmd_valid   <= cmd_valid_d;
            byte_count  <= byte_count_d;
            data_count  <= data_count_d;
            short_abort <= short_abort_d;
            cmd_overrun <= cmd_overrun_d;
        end
    end

endmodule
